// File: rtl/matrix_stream_loader.sv
// Loads a row-major element stream into a HEIGHT x WIDTH buffer, holds the
// completed frame for a consumer and serves it through a registered read port.
module matrix_stream_loader #(
  parameter int DATA_W = 8,
  parameter int WIDTH  = 3,
  parameter int HEIGHT = 3,
  parameter int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  parameter int COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              full,
  output logic              frame_done,
  output logic              err,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  output logic [DATA_W-1:0] rd_data,
  input  logic              frame_release
);

  // state  | meaning
  // S_LOAD | accepting elements into the buffer
  // S_HOLD | complete frame held until the consumer releases it
  typedef enum logic {S_LOAD, S_HOLD} state_t;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W:0]   ROW_CNT  = (ROW_W + 1)'(HEIGHT);
  localparam logic [COL_W:0]   COL_CNT  = (COL_W + 1)'(WIDTH);

  state_t state, state_nxt;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [DATA_W-1:0] mem [HEIGHT][WIDTH];
  logic xfer, is_final, rd_in_range;

  assign xfer        = in_valid && in_ready;
  assign is_final    = (row == ROW_LAST) && (col == COL_LAST);
  assign rd_in_range = ({1'b0, rd_row} < ROW_CNT) && ({1'b0, rd_col} < COL_CNT);

  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: if (xfer && is_final) state_nxt = S_HOLD;
      S_HOLD: if (frame_release)    state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready = (state == S_LOAD);
    full     = (state == S_HOLD);
  end

  // An early in_last restarts the frame at [0][0], same as a completed frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (xfer) begin
      if (is_final || in_last) begin
        row <= '0;
        col <= '0;
      end else if (col == COL_LAST) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= xfer && is_final;
      if (state == S_HOLD && frame_release)
        err <= 1'b0;
      else if (xfer && (is_final ? !in_last : in_last))
        err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) mem[row][col] <= in_data;
  end

  // Reads sample the array before this edge's write lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (rst)              rd_data <= '0;
    else if (rd_in_range) rd_data <= mem[rd_row][rd_col];
    else                  rd_data <= '0;
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader (3x3, 8-bit): load, read-back,
// framing errors, hold/release and mid-frame reset.
module tb_matrix_stream_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       full, frame_done, err;
  logic [1:0] rd_row = 2'd0;
  logic [1:0] rd_col = 2'd0;
  logic [7:0] rd_data;
  logic       frame_release = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  matrix_stream_loader #(.DATA_W(8), .WIDTH(3), .HEIGHT(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .full(full), .frame_done(frame_done),
    .err(err), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .frame_release(frame_release)
  );

  // Drives n elements starting at value first; valid follows pat (LSB first,
  // one bit per cycle). Stops after n transfers or a 64-cycle budget.
  task automatic stream(input logic [7:0] first, input int n, input int last_idx,
                        input logic [15:0] pat, output int cycles, output int pulses);
    int idx = 0;
    cycles = 0;
    pulses = 0;
    while (idx < n && cycles < 64) begin
      in_valid = pat[cycles % 16];
      in_data  = in_valid ? 8'(first + idx) : 8'hEE;
      in_last  = in_valid && (idx == last_idx);
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      cycles++;
      if (frame_done) pulses++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic rd(input int r, input int c, output logic [7:0] d);
    rd_row = 2'(r);
    rd_col = 2'(c);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic pulse_release();
    frame_release = 1'b1;
    @(negedge clk);
    frame_release = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc, pul;
    stream(8'h01, 9, 8, 16'hFFFF, cyc, pul);
    total++; if (cyc !== 9) begin bad++; $display("FAIL b2b_cycles got=%0d exp=9", cyc); end
    total++; if (pul !== 1) begin bad++; $display("FAIL b2b_pulses got=%0d exp=1", pul); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL b2b_full got=%b exp=1", full); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_in_ready got=%b exp=0", in_ready); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b exp=0", err); end
    @(negedge clk);
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL b2b_done_one_cycle got=%b exp=0", frame_done); end
  endtask

  task automatic test_read_port();
    logic [7:0] d;
    rd(0, 0, d);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL rd_00 got=%h exp=01", d); end
    rd(1, 2, d);
    total++; if (d !== 8'h06) begin bad++; $display("FAIL rd_12 got=%h exp=06", d); end
    rd(2, 2, d);
    total++; if (d !== 8'h09) begin bad++; $display("FAIL rd_22 got=%h exp=09", d); end
    rd(3, 0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL rd_row_oor got=%h exp=00", d); end
    rd(1, 3, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL rd_col_oor got=%h exp=00", d); end
    rd(2, 0, d);
    total++; if (d !== 8'h07) begin bad++; $display("FAIL rd_20 got=%h exp=07", d); end
  endtask

  task automatic test_release_basic();
    pulse_release();
    total++; if (full !== 1'b0) begin bad++; $display("FAIL rel_full got=%b exp=0", full); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_early_last();
    int cyc, pul;
    logic [7:0] d;
    stream(8'h01, 5, 4, 16'hFFFF, cyc, pul);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL early_err got=%b exp=1", err); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL early_full got=%b exp=0", full); end
    total++; if (pul !== 0) begin bad++; $display("FAIL early_pulses got=%0d exp=0", pul); end
    pulse_release();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL load_release_err got=%b exp=1", err); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL load_release_ready got=%b exp=1", in_ready); end
    stream(8'h0A, 9, 8, 16'hFFFF, cyc, pul);
    total++; if (pul !== 1) begin bad++; $display("FAIL early_frame_pulses got=%0d exp=1", pul); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL early_frame_full got=%b exp=1", full); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL early_frame_err got=%b exp=1", err); end
    rd(0, 0, d);
    total++; if (d !== 8'h0A) begin bad++; $display("FAIL early_rd_00 got=%h exp=0a", d); end
    rd(2, 2, d);
    total++; if (d !== 8'h12) begin bad++; $display("FAIL early_rd_22 got=%h exp=12", d); end
  endtask

  task automatic test_hold_release();
    logic [7:0] d;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
    end
    in_valid = 1'b0;
    pulse_release();
    total++; if (full !== 1'b0) begin bad++; $display("FAIL hold_rel_full got=%b exp=0", full); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_rel_ready got=%b exp=1", in_ready); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL hold_rel_err got=%b exp=0", err); end
    rd(0, 0, d);
    total++; if (d !== 8'h0A) begin bad++; $display("FAIL hold_rd_00 got=%h exp=0a", d); end
    rd(1, 1, d);
    total++; if (d !== 8'h0E) begin bad++; $display("FAIL hold_rd_11 got=%h exp=0e", d); end
    rd(2, 2, d);
    total++; if (d !== 8'h12) begin bad++; $display("FAIL hold_rd_22 got=%h exp=12", d); end
  endtask

  task automatic test_valid_toggle();
    int cyc, pul;
    logic [7:0] d;
    stream(8'h01, 9, 8, 16'b1011_0011_0101_1101, cyc, pul);
    total++; if (cyc !== 14) begin bad++; $display("FAIL tog_cycles got=%0d exp=14", cyc); end
    total++; if (pul !== 1) begin bad++; $display("FAIL tog_pulses got=%0d exp=1", pul); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL tog_err got=%b exp=0", err); end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        rd(r, c, d);
        total++;
        if (d !== 8'(r * 3 + c + 1)) begin
          bad++;
          $display("FAIL tog_rd_%0d%0d got=%h exp=%h", r, c, d, 8'(r * 3 + c + 1));
        end
      end
    pulse_release();
  endtask

  task automatic test_reset_mid_frame();
    int cyc, pul;
    logic [7:0] d;
    stream(8'h51, 4, -1, 16'hFFFF, cyc, pul);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", in_ready); end
    stream(8'h21, 9, 8, 16'hFFFF, cyc, pul);
    total++; if (pul !== 1) begin bad++; $display("FAIL midrst_pulses got=%0d exp=1", pul); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL midrst_full got=%b exp=1", full); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b exp=0", err); end
    rd(0, 0, d);
    total++; if (d !== 8'h21) begin bad++; $display("FAIL midrst_rd_00 got=%h exp=21", d); end
    rd(1, 0, d);
    total++; if (d !== 8'h24) begin bad++; $display("FAIL midrst_rd_10 got=%h exp=24", d); end
    rd(2, 2, d);
    total++; if (d !== 8'h29) begin bad++; $display("FAIL midrst_rd_22 got=%h exp=29", d); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_read_port();
    test_release_basic();
    test_early_last();
    test_hold_release();
    test_valid_toggle();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_stream_loader.md
Name: matrix_stream_loader

Overview:
Receives a row-major stream of matrix elements over a valid/ready handshake and writes them into an internal HEIGHT x WIDTH element buffer. It is the producer side of the 2D image/weight arrays that the matrix-operation blocks consume. Once a full matrix is loaded, it holds the frame and exposes it through a registered random-access read port. A downstream consumer releases the frame when it has finished with it. The block also checks frame framing with an in_last marker.

Parameters:
DATA_W, 8, element width in bits
WIDTH, 3, columns per matrix (>=1)
HEIGHT, 3, rows per matrix (>=1)
ROW_W, max(1,$clog2(HEIGHT)), row index width (derived)
COL_W, max(1,$clog2(WIDTH)), column index width (derived)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input element valid
in_ready  out  1  block can accept an element
in_data  in  DATA_W  input element, row-major order
in_last  in  1  marks last element of the matrix
full  out  1  complete matrix held in buffer
frame_done  out  1  one-cycle pulse when a matrix completes
err  out  1  sticky framing error
rd_row  in  ROW_W  read row index
rd_col  in  COL_W  read column index
rd_data  out  DATA_W  registered read data
release  in  1  consumer has finished with the held matrix

Behaviour:
- Reset (clk edge with rst=1):
  - state=LOAD; row and column counters = 0.
  - full=0, frame_done=0, err=0, rd_data=0.
  - in_ready=1 in the first cycle after reset.
  - Buffer contents are not reset.
  - Reset mid-frame discards the partial frame.
- in_ready is decoded from state: 1 in LOAD, 0 in HOLD.
- Handshake:
  - An element transfers on a clk edge where in_valid && in_ready.
  - in_data must be stable while in_valid=1 && in_ready=0.
- LOAD, on each transfer:
  - Write buf[row][col] <= in_data.
  - If col==WIDTH-1: col<=0 and row<=row+1. Otherwise col<=col+1.
- Final element is the transfer at row==HEIGHT-1, col==WIDTH-1:
  - Next state HOLD; row and col return to 0.
  - full=1 and frame_done=1 in the following cycle. frame_done is high for exactly 1 cycle.
  - If in_last=0 on the final element: err<=1, and the frame is still committed to HOLD.
- Early in_last (in_last=1 on any non-final transfer):
  - That element is written.
  - err<=1; counters reset to 0; state stays LOAD.
  - The next transfer is treated as element [0][0].
- HOLD:
  - No writes; in_ready=0.
  - release=1 -> state LOAD, full<=0, err<=0. in_ready=1 in the next cycle.
- release in LOAD is ignored, and it does not clear err.
- err is cleared only by rst or by release in HOLD.
- Read port:
  - rd_data <= buf[rd_row][rd_col] on every clk edge, in any state. Latency is 1 cycle.
  - Out-of-range index (rd_row>=HEIGHT or rd_col>=WIDTH) gives rd_data<=0.
  - Read and write of the same cell in the same cycle returns the old value (read-before-write).
- Degenerate sizes: WIDTH=1 and/or HEIGHT=1 are supported. For 1x1, every transfer is the final element.
- Back-to-back frames: maximum throughput is 1 element per cycle in LOAD. There is no transfer in the cycle where release is sampled.

Test Plan:
- Reset, then stream 01..09 with in_valid held high and in_last on the 9th -> 9 transfers in 9 cycles; frame_done pulses once; full=1; in_ready=0; err=0.
- After the load, read [0][0], [1][2], [2][2] -> rd_data = 01, 06, 09, each one cycle after its address.
- Toggle in_valid randomly while streaming 01..09 -> buffer contents are identical to the back-to-back case; no element is skipped or duplicated.
- Assert in_last on the 5th element (05), then stream 0A..12 with in_last on 12 -> err=1; buf[0][0]=0A and buf[2][2]=12; full=1.
- In HOLD, drive in_valid=1 with data FF for 5 cycles, then pulse release -> buffer is unchanged, full falls, in_ready rises the next cycle, err clears.
- Reset mid-frame after 4 elements, then stream 21..29 -> frame completes normally; buf[0][0]=21; err=0.
- Read [3][0] (out of range) -> rd_data=00.
